// File: rtl/p4_bd_channel_pkg.sv
// Shared types for the 4-phase bundled-data rendezvous channel.
package p4_bd_channel_pkg;

  localparam int CH_WIDTH_DEF     = 64;
  localparam int CH_CNT_WIDTH_DEF = 16;

  // Encoding doubles as the externally visible status code.
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_REQ  = 2'd1,
    CH_ACK  = 2'd2,
    CH_RTZ  = 2'd3
  } ch_state_t;

endpackage

// File: rtl/p4_bd_channel.sv
// Point-to-point CSP Send/Receive rendezvous. A word moves only when a sender
// and a receiver are both pending, using a req/ack return-to-zero handshake
// whose wires are exposed for observation. Four cycles minimum per word.
module p4_bd_channel
  import p4_bd_channel_pkg::*;
#(
  parameter int WIDTH     = CH_WIDTH_DEF,
  parameter int CNT_WIDTH = CH_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 snd_valid,
  input  logic [WIDTH-1:0]     snd_data,
  output logic                 snd_done,
  input  logic                 rcv_ready,
  output logic [WIDTH-1:0]     rcv_data,
  output logic                 rcv_done,
  output logic                 peek_valid,
  output logic                 req,
  output logic                 ack,
  output logic [WIDTH-1:0]     data_bus,
  output logic [1:0]           status,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  ch_state_t            state_q, state_d;
  logic                 req_q, req_d;
  logic                 ack_q, ack_d;
  logic [WIDTH-1:0]     bus_q, bus_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 rdone_q, rdone_d;
  logic                 sdone_q, sdone_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next-state: one phase per cycle; only IDLE and REQ wait on the outside world.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = ack_q;
    bus_d   = bus_q;
    rdata_d = rdata_q;
    rdone_d = 1'b0;
    sdone_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      CH_IDLE: begin
        // ack is already low here, so raising req keeps the handshake legal.
        if (snd_valid) begin
          bus_d   = snd_data;
          req_d   = 1'b1;
          state_d = CH_REQ;
        end
      end
      CH_REQ: begin
        // Word is latched; a receiver withdrawing just keeps us parked here.
        if (rcv_ready) begin
          ack_d   = 1'b1;
          rdata_d = bus_q;
          rdone_d = 1'b1;
          state_d = CH_ACK;
        end
      end
      CH_ACK: begin
        req_d   = 1'b0;
        state_d = CH_RTZ;
      end
      CH_RTZ: begin
        ack_d   = 1'b0;
        sdone_d = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight word silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      bus_q   <= '0;
      rdata_q <= '0;
      rdone_q <= 1'b0;
      sdone_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
      rdone_q <= rdone_d;
      sdone_q <= sdone_d;
      cnt_q   <= cnt_d;
    end
  end

  assign snd_done   = sdone_q;
  assign rcv_data   = rdata_q;
  assign rcv_done   = rdone_q;
  assign peek_valid = (state_q == CH_REQ);
  assign req        = req_q;
  assign ack        = ack_q;
  assign data_bus   = bus_q;
  assign status     = state_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_p4_bd_channel.sv
// Directed bench for the rendezvous channel; a second instance with a 2-bit
// counter shares the stimulus to exercise counter wrap.
module tb_p4_bd_channel;

  logic        clk, rst_n;
  logic        snd_valid, rcv_ready;
  logic [63:0] snd_data;
  logic        snd_done, rcv_done, peek_valid, req, ack;
  logic [63:0] rcv_data, data_bus;
  logic [1:0]  status;
  logic [15:0] xfer_count;

  logic        snd_done_2, rcv_done_2, peek_valid_2, req_2, ack_2;
  logic [63:0] rcv_data_2, data_bus_2;
  logic [1:0]  status_2;
  logic [1:0]  xfer_count_2;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  p4_bd_channel #(.WIDTH(64), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .snd_valid(snd_valid), .snd_data(snd_data), .snd_done(snd_done),
    .rcv_ready(rcv_ready), .rcv_data(rcv_data), .rcv_done(rcv_done),
    .peek_valid(peek_valid), .req(req), .ack(ack), .data_bus(data_bus),
    .status(status), .xfer_count(xfer_count)
  );

  p4_bd_channel #(.WIDTH(64), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .snd_valid(snd_valid), .snd_data(snd_data), .snd_done(snd_done_2),
    .rcv_ready(rcv_ready), .rcv_data(rcv_data_2), .rcv_done(rcv_done_2),
    .peek_valid(peek_valid_2), .req(req_2), .ack(ack_2), .data_bus(data_bus_2),
    .status(status_2), .xfer_count(xfer_count_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sdone"}, snd_done, 0);
    chk({tag, "_rdone"}, rcv_done, 0);
    chk({tag, "_peek"},  peek_valid, 0);
    chk({tag, "_req"},   req, 0);
    chk({tag, "_ack"},   ack, 0);
    chk({tag, "_bus"},   data_bus, 0);
    chk({tag, "_rdata"}, rcv_data, 0);
    chk({tag, "_st"},    status, 0);
    chk({tag, "_cnt"},   xfer_count, 0);
  endtask

  // One full Send; called at a negedge with the channel idle. Receiver joins
  // after 'late' waiting cycles in REQ; 'glitch' flashes rcv_ready between edges.
  task automatic send_word(input logic [63:0] d, input int late, input bit glitch);
    snd_valid = 1'b1;
    snd_data  = d;
    rcv_ready = (late == 0);
    tick;
    for (int i = 0; i <= late; i++) begin
      chk("req_st", status, 1);
      chk("req_req", req, 1);
      chk("req_ack", ack, 0);
      chk("req_peek", peek_valid, 1);
      chk("req_bus", data_bus, d);
      chk("req_no_rdone", rcv_done, 0);
      chk("req_no_sdone", snd_done, 0);
      snd_data = ~d;
      if (glitch && i < late) begin
        rcv_ready = 1'b1;
        #1;
        rcv_ready = 1'b0;
      end
      rcv_ready = (i == late);
      tick;
    end
    chk("ack_st", status, 2);
    chk("ack_req", req, 1);
    chk("ack_ack", ack, 1);
    chk("ack_peek", peek_valid, 0);
    chk("ack_rdone", rcv_done, 1);
    chk("ack_rdata", rcv_data, d);
    chk("ack_bus", data_bus, d);
    chk("ack_no_sdone", snd_done, 0);
    rcv_ready = 1'b0;
    tick;
    chk("rtz_st", status, 3);
    chk("rtz_req", req, 0);
    chk("rtz_ack", ack, 1);
    chk("rtz_rdone", rcv_done, 0);
    chk("rtz_no_sdone", snd_done, 0);
    chk("rtz_rdata", rcv_data, d);
    tick;
    exp_cnt++;
    chk("done_st", status, 0);
    chk("done_sdone", snd_done, 1);
    chk("done_req", req, 0);
    chk("done_ack", ack, 0);
    chk("done_rdone", rcv_done, 0);
    chk("done_rdata", rcv_data, d);
    chk("done_cnt", xfer_count, 64'(exp_cnt % 65536));
    chk("done_cnt2", xfer_count_2, 64'(exp_cnt % 4));
    snd_valid = 1'b0;
    snd_data  = '0;
  endtask

  initial begin
    rst_n = 1'b0; snd_valid = 1'b0; rcv_ready = 1'b0; snd_data = '0;
    repeat (2) tick;
    chk_zero("rst_held");
    rst_n = 1'b1;
    tick;
    chk_zero("rst_rel");

    // Reset in the middle of REQ discards the word with no done pulse.
    snd_valid = 1'b1; snd_data = 64'hFFFF;
    tick;
    chk("t1_req", req, 1);
    chk("t1_bus", data_bus, 64'hFFFF);
    #2 rst_n = 1'b0;
    #1 chk_zero("t1_async");
    snd_valid = 1'b0; snd_data = '0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t1_post_sdone", snd_done, 0);
      chk("t1_post_rdone", rcv_done, 0);
      chk("t1_post_st", status, 0);
      chk("t1_post_cnt2", xfer_count_2, 0);
    end

    // Receiver pending in IDLE before sender: no effect.
    rcv_ready = 1'b1;
    repeat (3) begin
      tick;
      chk("t2_idle_st", status, 0);
      chk("t2_idle_rdone", rcv_done, 0);
    end
    rcv_ready = 1'b0;

    // Basic transfer, both sides arrive together.
    send_word(64'h1004_0000_0000_ABCD, 0, 1'b0);
    tick;
    chk("t2_sdone_drop", snd_done, 0);
    chk("t2_rdata_hold", rcv_data, 64'h1004_0000_0000_ABCD);

    // Late receiver: 10 cycles parked in REQ.
    send_word(64'hDEAD_BEEF_0123_4567, 10, 1'b0);
    tick;

    // Back-to-back 0..24, new word offered on the snd_done cycle.
    for (int i = 0; i < 25; i++) begin
      send_word(64'(i), 0, 1'b0);
      if (exp_cnt == 5) chk("wrap5", xfer_count_2, 1);
    end
    tick;
    chk("t4_cnt", xfer_count, 27);
    chk("t4_idle", status, 0);
    chk("t4_sdone_drop", snd_done, 0);

    // Receiver flashes ready between edges and withdraws; bus must hold.
    send_word(64'h5555_AAAA_0F0F_F0F0, 4, 1'b1);
    tick;
    chk("t5_cnt", xfer_count, 28);
    chk("t5_cnt2", xfer_count_2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
